// File: rtl/uart_tx_param_if.sv
// UART transmitter bus: parallel word handshake, frame settings, serial line and busy.
// Ports: P_DATA/DATA_VALID/DATA_READY handshake, PAR_EN/PAR_TYP/STOP2/PRESCALE frame settings,
//        S_DATA serial output, busy frame-in-progress flag. master = data source, slave = transmitter.
interface uart_tx_param_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      DATA_VALID;
    logic                      DATA_READY;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic                      STOP2;
    logic [PRESCALE_WIDTH-1:0] PRESCALE;
    logic                      S_DATA;
    logic                      busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2, PRESCALE,
        input  DATA_READY, S_DATA, busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2, PRESCALE,
        output DATA_READY, S_DATA, busy
    );
endinterface

// File: rtl/uart_tx_param.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
// Latency: start bit appears on S_DATA the cycle after acceptance; each bit lasts max(PRESCALE,1) cycles.
// Backpressure: DATA_READY = ~busy by default; with UART_TX_SKID_EN a one-entry pending buffer
//   makes DATA_READY = buffer empty and chains frames back to back with no idle cycle.
// Ports: CLK, RST (synchronous, active-high), bus (uart_tx_param_if.slave).
module uart_tx_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic            CLK,
    input  logic            RST,
    uart_tx_param_if.slave  bus
);

    localparam int BIDX_W = $clog2(DATA_WIDTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Everything a frame needs, captured together at acceptance.
    typedef struct packed {
        logic [DATA_WIDTH-1:0]     data;
        logic                      par_en;
        logic                      par_bit;
        logic                      stop2;
        logic [PRESCALE_WIDTH-1:0] prescale;
    } frame_t;

    logic [2:0]                state;
    frame_t                    cur;
    frame_t                    in_frame;
    frame_t                    load_frame;
    frame_t                    pend;
    logic                      pend_vld;
    logic [PRESCALE_WIDTH-1:0] cyc_cnt;
    logic [BIDX_W-1:0]         bit_idx;
    logic                      stop_second;
    logic                      s_data_q;
    logic                      busy_q;
    logic                      ready;
    logic                      accept;
    logic                      bit_end;
    logic                      frame_done;
    logic                      load_new;

    // Parity is resolved here so the frame never depends on live inputs after acceptance.
    always_comb begin
        in_frame          = '0;
        in_frame.data     = bus.P_DATA;
        in_frame.par_en   = bus.PAR_EN;
        in_frame.par_bit  = (^bus.P_DATA) ^ bus.PAR_TYP;
        in_frame.stop2    = bus.STOP2;
        in_frame.prescale = (bus.PRESCALE == '0) ? PRESCALE_WIDTH'(1) : bus.PRESCALE;
    end

`ifdef UART_TX_SKID_EN
    assign ready = ~pend_vld;

    // Pending word is taken only while a frame is running and not exactly at its end;
    // a word arriving on the final stop cycle with an empty buffer starts directly instead.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_vld <= 1'b0;
            pend     <= '0;
        end else if (frame_done && pend_vld) begin
            pend_vld <= 1'b0;
        end else if (accept && (state != ST_IDLE) && !frame_done) begin
            pend_vld <= 1'b1;
            pend     <= in_frame;
        end
    end
`else
    assign pend     = '0;
    assign pend_vld = 1'b0;
    // busy_q is set on the accepting edge, so ready falls right after acceptance.
    assign ready    = ~busy_q;
`endif

    assign accept     = bus.DATA_VALID & ready;
    assign bit_end    = (cyc_cnt == (cur.prescale - PRESCALE_WIDTH'(1)));
    assign frame_done = (state == ST_STOP) && bit_end && (!cur.stop2 || stop_second);
    assign load_new   = ((state == ST_IDLE) && accept) || (frame_done && (pend_vld || accept));
    assign load_frame = pend_vld ? pend : in_frame;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            cur         <= '0;
            cyc_cnt     <= '0;
            bit_idx     <= '0;
            stop_second <= 1'b0;
            s_data_q    <= 1'b1;
            busy_q      <= 1'b0;
        end else if (load_new) begin
            state       <= ST_START;
            cur         <= load_frame;
            cyc_cnt     <= '0;
            bit_idx     <= '0;
            stop_second <= 1'b0;
            s_data_q    <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    s_data_q <= 1'b1;
                    busy_q   <= 1'b0;
                end
                ST_START: begin
                    if (bit_end) begin
                        cyc_cnt  <= '0;
                        state    <= ST_DATA;
                        bit_idx  <= '0;
                        s_data_q <= cur.data[0];
                        cur.data <= cur.data >> 1;
                    end else begin
                        cyc_cnt <= cyc_cnt + PRESCALE_WIDTH'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_idx == BIDX_W'(DATA_WIDTH - 1)) begin
                            if (cur.par_en) begin
                                state    <= ST_PARITY;
                                s_data_q <= cur.par_bit;
                            end else begin
                                state    <= ST_STOP;
                                s_data_q <= 1'b1;
                            end
                        end else begin
                            // Data register shifts right so bit 0 is always the next bit out.
                            bit_idx  <= bit_idx + BIDX_W'(1);
                            s_data_q <= cur.data[0];
                            cur.data <= cur.data >> 1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + PRESCALE_WIDTH'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        cyc_cnt  <= '0;
                        state    <= ST_STOP;
                        s_data_q <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + PRESCALE_WIDTH'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (frame_done) begin
                            state    <= ST_IDLE;
                            busy_q   <= 1'b0;
                            s_data_q <= 1'b1;
                        end else begin
                            stop_second <= 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + PRESCALE_WIDTH'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    s_data_q <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.S_DATA     = s_data_q;
    assign bus.busy       = busy_q;
    assign bus.DATA_READY = ready;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: an 8-bit instance checked every cycle against a frame-list model,
// plus a 5-bit instance and literal frame patterns that pin the model.
// Build with or without UART_TX_SKID_EN; the expectations follow the same macro.
module tb_uart_tx_param;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_tx_param_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(8)) bus8 ();
    uart_tx_param_if #(.DATA_WIDTH(5), .PRESCALE_WIDTH(8)) bus5 ();

    uart_tx_param #(.DATA_WIDTH(8), .PRESCALE_WIDTH(8)) dut8 (.CLK(CLK), .RST(RST), .bus(bus8));
    uart_tx_param #(.DATA_WIDTH(5), .PRESCALE_WIDTH(8)) dut5 (.CLK(CLK), .RST(RST), .bus(bus5));

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Expected line, one entry per cycle, for every frame the model has accepted.
    bit exp_s[$];
    bit exp_end[$];
    int frames_q = 0;

    logic [63:0] cap_s;
    logic [63:0] cap_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ones(input logic [63:0] v);
        int n = 0;
        for (int i = 0; i < 64; i++) if (v[i] === 1'b1) n++;
        return n;
    endfunction

    // Frame as a list of bit values, each repeated for the bit period.
    function automatic void push_frame(input logic [7:0] d, input bit pen, input bit ptyp,
                                       input bit st2, input logic [7:0] presc);
        int p;
        int cnt1;
        bit bits[$];
        p = (presc == 8'd0) ? 1 : int'(presc);
        cnt1 = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            bits.push_back(d[i]);
            if (d[i]) cnt1++;
        end
        if (pen) bits.push_back(((cnt1 % 2) == 1) ? ~ptyp : ptyp);
        bits.push_back(1'b1);
        if (st2) bits.push_back(1'b1);
        for (int k = 0; k < bits.size(); k++) begin
            for (int j = 0; j < p; j++) begin
                exp_s.push_back(bits[k]);
                exp_end.push_back((k == bits.size() - 1) && (j == p - 1));
            end
        end
        frames_q++;
    endfunction

    always @(negedge CLK) begin : cmp
        bit es;
        bit eb;
        bit er;
        bit fe;
        if (chk_en) begin
            if (exp_s.size() > 0) begin
                es = exp_s[0];
                eb = 1'b1;
            end else begin
                es = 1'b1;
                eb = 1'b0;
            end
`ifdef UART_TX_SKID_EN
            er = (frames_q <= 1);
`else
            er = (frames_q == 0);
`endif
            check("line_s_data", bus8.S_DATA, es);
            check("line_busy", bus8.busy, eb);
            check("line_ready", bus8.DATA_READY, er);
            if (exp_s.size() > 0) begin
                fe = exp_end.pop_front();
                void'(exp_s.pop_front());
                if (fe) frames_q--;
            end
            if (RST) begin
                exp_s.delete();
                exp_end.delete();
                frames_q = 0;
            end else if (bus8.DATA_VALID && er) begin
                push_frame(bus8.P_DATA, bus8.PAR_EN, bus8.PAR_TYP, bus8.STOP2, bus8.PRESCALE);
            end
        end
    end

    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    // Presents a word and returns one cycle into its frame (just after the accepting edge).
    task automatic send8(input logic [7:0] d, input bit pen, input bit ptyp, input bit st2,
                         input logic [7:0] presc);
        int n = 0;
        bus8.P_DATA     = d;
        bus8.PAR_EN     = pen;
        bus8.PAR_TYP    = ptyp;
        bus8.STOP2      = st2;
        bus8.PRESCALE   = presc;
        bus8.DATA_VALID = 1'b1;
        do begin
            @(negedge CLK);
            n++;
        end while (!bus8.DATA_READY && n < 300);
        check("send_ready_wait", bus8.DATA_READY, 1'b1);
        @(posedge CLK);
        #1;
        bus8.DATA_VALID = 1'b0;
    endtask

    task automatic capture8(input int n, output logic [63:0] s, output logic [63:0] b);
        s = '1;
        b = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            s[i] = bus8.S_DATA;
            b[i] = bus8.busy;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] s5;
        logic [63:0] b5;
        bus8.P_DATA = '0; bus8.DATA_VALID = 1'b0; bus8.PAR_EN = 1'b0;
        bus8.PAR_TYP = 1'b0; bus8.STOP2 = 1'b0; bus8.PRESCALE = 8'd1;
        bus5.P_DATA = '0; bus5.DATA_VALID = 1'b0; bus5.PAR_EN = 1'b0;
        bus5.PAR_TYP = 1'b0; bus5.STOP2 = 1'b0; bus5.PRESCALE = 8'd1;

        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk_en = 1'b1;
        @(negedge CLK);
        check("rst_s_data", bus8.S_DATA, 1'b1);
        check("rst_busy", bus8.busy, 1'b0);
        check("rst_ready", bus8.DATA_READY, 1'b1);
        check("rst5_s_data", bus5.S_DATA, 1'b1);
        check("rst5_busy", bus5.busy, 1'b0);
        sync();

        // 0x81, even parity, one stop, 1-cycle bits.
        send8(8'h81, 1'b1, 1'b0, 1'b0, 8'd1);
        capture8(13, cap_s, cap_b);
        check("f81_bits", cap_s[10:0], 11'b10100000010);
        check("f81_busy_cycles", ones(cap_b), 11);
        check("f81_idle_after", cap_b[11], 1'b0);

        // 0x0A, odd parity, two stops, 4-cycle bits: 48-cycle frame.
        send8(8'h0A, 1'b1, 1'b1, 1'b1, 8'd4);
        capture8(52, cap_s, cap_b);
        check("f0a_d7", cap_s[35], 1'b0);
        check("f0a_parity", cap_s[36], 1'b1);
        check("f0a_parity_held", cap_s[39], 1'b1);
        check("f0a_busy_cycles", ones(cap_b), 48);

        // PRESCALE=0 behaves as 1.
        send8(8'h5C, 1'b0, 1'b0, 1'b0, 8'd0);
        capture8(12, cap_s, cap_b);
        check("p0_busy_cycles", ones(cap_b), 10);

        // Settings changed mid-frame must not touch the running frame.
        send8(8'h3A, 1'b1, 1'b0, 1'b0, 8'd2);
        bus8.PRESCALE = 8'd8;
        bus8.P_DATA   = 8'hFF;
        bus8.PAR_EN   = 1'b0;
        bus8.STOP2    = 1'b1;
        capture8(30, cap_s, cap_b);
        check("latched_busy_cycles", ones(cap_b), 22);
        check("latched_d1", cap_s[4], 1'b1);

        // Second word presented while the first is on the line.
        send8(8'h0A, 1'b0, 1'b0, 1'b0, 8'd1);
        fork
            capture8(24, cap_s, cap_b);
            send8(8'h91, 1'b0, 1'b0, 1'b0, 8'd1);
        join
        check("chain_stop1", cap_s[9], 1'b1);
`ifdef UART_TX_SKID_EN
        check("chain_start2", cap_s[10], 1'b0);
        check("chain_busy_gap", cap_b[10], 1'b1);
        check("chain2_d0", cap_s[11], 1'b1);
`else
        check("chain_idle_s", cap_s[10], 1'b1);
        check("chain_idle_busy", cap_b[10], 1'b0);
        check("chain_start2", cap_s[11], 1'b0);
`endif
        check("chain_busy_cycles", ones(cap_b), 20);

        // Reset during data bit 3.
        send8(8'hA5, 1'b0, 1'b0, 1'b0, 8'd1);
        repeat (4) sync();
        RST = 1'b1;
        sync();
        RST = 1'b0;
        @(negedge CLK);
        check("midrst_s_data", bus8.S_DATA, 1'b1);
        check("midrst_busy", bus8.busy, 1'b0);
        check("midrst_ready", bus8.DATA_READY, 1'b1);
        sync();
        send8(8'h3C, 1'b1, 1'b1, 1'b0, 8'd1);
        capture8(14, cap_s, cap_b);
        check("postrst_start", cap_s[0], 1'b0);
        check("postrst_busy_cycles", ones(cap_b), 11);

        // Valid pulse during a frame: accepted only if the block says ready.
        send8(8'h33, 1'b1, 1'b0, 1'b1, 8'd2);
        bus8.P_DATA     = 8'hEE;
        bus8.DATA_VALID = 1'b1;
        sync();
        sync();
        bus8.DATA_VALID = 1'b0;
        repeat (60) sync();

        // 5-bit instance: 0x15 with no parity.
        bus5.P_DATA     = 5'h15;
        bus5.DATA_VALID = 1'b1;
        @(negedge CLK);
        check("dw5_ready", bus5.DATA_READY, 1'b1);
        sync();
        bus5.DATA_VALID = 1'b0;
        s5 = '1;
        b5 = '0;
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            s5[i] = bus5.S_DATA;
            b5[i] = bus5.busy;
        end
        check("dw5_bits", s5[6:0], 7'b1101010);
        check("dw5_busy_cycles", ones(b5), 7);
        check("dw5_idle_after", s5[7], 1'b1);
        sync();

        repeat (20) sync();
        check("model_drained", exp_s.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 8, meaning width of the PRESCALE port.
REQ-003 SHALL have port CLK  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port P_DATA  input  DATA_WIDTH  parallel data; LSB is sent first.
REQ-006 SHALL have port DATA_VALID  input  1  request to send P_DATA.
REQ-007 SHALL have port DATA_READY  output  1  the block accepts P_DATA this cycle when DATA_VALID=1.
REQ-008 SHALL have port PAR_EN  input  1  1 inserts a parity bit.
REQ-009 SHALL have port PAR_TYP  input  1  0 selects even parity; 1 selects odd parity.
REQ-010 SHALL have port STOP2  input  1  0 selects one stop bit; 1 selects two stop bits.
REQ-011 SHALL have port PRESCALE  input  PRESCALE_WIDTH  CLK cycles per bit; a value of 0 is treated as 1.
REQ-012 SHALL have port S_DATA  output  1  serial line; idles at 1.
REQ-013 SHALL have port busy  output  1  a frame is on the line.

Function
REQ-014 A transfer SHALL be accepted on a rising edge where DATA_VALID=1 and DATA_READY=1.
REQ-015 States SHALL be IDLE, START, DATA, PARITY and STOP, with S_DATA registered.
REQ-016 Transitions SHALL be:
- IDLE to START on acceptance.
- START to DATA.
- DATA to PARITY after DATA_WIDTH bits when PAR_EN=1; DATA to STOP after DATA_WIDTH bits otherwise.
- PARITY to STOP.
- STOP to START when a frame is pending; STOP to IDLE otherwise.
REQ-017 Each bit SHALL last exactly max(PRESCALE,1) cycles, counted by a bit-period counter.
REQ-018 The frame SHALL be: start bit 0, then data bits LSB first, then parity if enabled, then 1 or 2 stop bits of 1.
REQ-019 Timing of the start bit and busy SHALL be:
- S_DATA drives the start bit on the cycle after acceptance.
- busy=1 from that cycle until the last stop bit period ends.
- busy=0 in IDLE.
REQ-020 Parity SHALL be computed at frame start: XOR of the data for even parity; the inverse of that for odd parity.
REQ-021 Frame settings SHALL be captured at acceptance and held for the whole frame:
- P_DATA, PAR_EN, PAR_TYP, STOP2 and PRESCALE are latched at the accepting edge.
- Changes to these inputs mid-frame have no effect on the frame in progress.
REQ-022 DATA_VALID asserted while DATA_READY=0 SHALL be ignored, with no side effects.
REQ-023 Frame length SHALL be 1 + DATA_WIDTH + PAR_EN + 1 + STOP2 bit periods.

Reset
REQ-024 RST=1 on any edge, including mid-frame, SHALL set the following outputs and state:
- state=IDLE, S_DATA=1, busy=0.
- All counters cleared; the pending buffer is emptied.
- DATA_READY=1 from the next cycle.
REQ-025 A truncated frame SHALL NOT resume after reset.

Configuration
REQ-026 When macro UART_TX_SKID_EN is defined, the block SHALL contain a one-entry pending buffer:
- DATA_READY = buffer empty.
- A word may be accepted while busy=1.
- The pending frame's start bit follows the last stop bit directly, with no idle cycle; busy stays 1 across the boundary.
REQ-027 When UART_TX_SKID_EN is undefined, the block SHALL have no buffer:
- DATA_READY = ~busy, and also 0 on the acceptance cycle.
- At least one IDLE cycle separates frames.

Verification
REQ-028 PRESCALE=1, PAR_EN=1, PAR_TYP=0, STOP2=0, P_DATA=8'h81 -> S_DATA sequence 0,1,0,0,0,0,0,0,1,0,1, one cycle each; busy high for 11 cycles.
REQ-029 PRESCALE=4, PAR_EN=1, PAR_TYP=1, STOP2=1, P_DATA=8'h0A -> each bit held 4 cycles; parity bit=1; two stop bits; frame length 48 cycles.
REQ-030 Skid buffer, compiled both ways: PRESCALE=1, PAR_EN=0, 8'h0A then 8'h91 presented while busy.
- With UART_TX_SKID_EN: the 8'h91 start bit lands in the cycle right after the 8'h0A stop bit.
- Without UART_TX_SKID_EN: 8'h91 is held off until DATA_READY=1.
REQ-031 DATA_WIDTH=5, P_DATA=5'h15, PAR_EN=0 -> S_DATA sequence 0,1,0,1,0,1,1; bits above DATA_WIDTH ignored.
REQ-032 Reset mid-frame: RST=1 during data bit 3 -> next cycle S_DATA=1, busy=0, DATA_READY=1; the next accepted word is sent as a full frame.
REQ-033 PRESCALE=0, then PRESCALE changed mid-frame from 2 to 8 -> the frame uses the 1-cycle period, then the latched value of 2 throughout.
